pu_riscv_memalign: RTL and testbench
====================================

# pu_riscv_memalign

Parametrised misalignment checker and access splitter between the CPU load/store/fetch path and the memory subsystem. It classifies each request against natural alignment. When splitting is enabled, it turns misaligned data accesses into one or two XLEN-aligned bus beats with byte enables and merges the read data. Otherwise, and for all instruction fetches, it raises a registered misalignment exception.

## Interface
Parameters:
- XLEN, 64, data/address width; 32 or 64.
- HAS_RVC, 1, nonzero: fetches need 2-byte alignment; zero: fetches need 4-byte alignment.
- SPLIT_EN, 1, nonzero: misaligned data accesses are split or masked; zero: they raise misaligned_o.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  CPU request; held until ack_o or misaligned_o.
- instruction_i  in  1  request is an instruction fetch.
- we_i  in  1  store (ignored when instruction_i=1).
- adr_i  in  XLEN  byte address.
- size_i  in  3  BYTE/HWORD/WORD/DWORD codes from peripheral_biu_verilog_pkg.
- d_i  in  XLEN  store data, right-justified.
- ack_o  out  1  one-cycle completion pulse.
- q_o  out  XLEN  load data, right-justified, zero above the access size; valid while ack_o=1.
- misaligned_o  out  1  one-cycle exception pulse, no memory access performed.
- mem_req_o  out  1  memory beat request; held until mem_ack_i.
- mem_adr_o  out  XLEN  beat address, aligned to XLEN/8.
- mem_we_o  out  1  beat is a write.
- mem_be_o  out  XLEN/8  byte enables.
- mem_d_o  out  XLEN  beat write data, lane-positioned.
- mem_ack_i  in  1  beat complete; mem_q_i valid.
- mem_q_i  in  XLEN  beat read data.

## Operation
- B = XLEN/8; off = adr_i mod B; n = 1/2/4/8 bytes for BYTE/HWORD/WORD/DWORD.
- Illegal size: any other code, or DWORD with XLEN=32. An illegal size is always an error.
- Fetch error: adr_i[0] when HAS_RVC≠0, else |adr_i[1:0]. Fetches are never split; an aligned fetch runs as a single beat.
- Data misaligned: adr_i mod n ≠ 0. With SPLIT_EN=0 this is an error.
- Mask M = ((1<<n)-1) << off, 2B bits wide. Shifted store data S = d_i << 8·off, 2·XLEN bits wide.
- Beat 0: address adr_i with low log2(B) bits cleared; be = M[B-1:0]; data = S[XLEN-1:0].
- Beat 1: issued only if M[2B-1:B] ≠ 0, at beat-0 address + B (wraps modulo 2^XLEN); be = M[2B-1:B]; data = S[2XLEN-1:XLEN].
- Load merge: q = ({beat1_q, beat0_q} >> 8·off) masked to n bytes. beat1_q is treated as 0 when beat 1 is not issued.
- States and transitions:
  - IDLE: samples req_i. Error → ERR. Otherwise → BEAT0, with address, size, we, data and off captured into registers.
  - BEAT0: on mem_ack_i → BEAT1 if beat 1 is needed, else → DONE.
  - BEAT1: on mem_ack_i → DONE.
  - DONE: ack_o=1 → IDLE.
  - ERR: misaligned_o=1 → IDLE.
- Captured registers are stable for the whole operation. Changes on the req_i/adr_i/size_i/d_i ports after acceptance are ignored. req_i deasserting mid-operation does not abort it.
- mem_ack_i outside BEAT0/BEAT1 is ignored.

## Timing
- Reset: state=IDLE. ack_o, misaligned_o, mem_req_o, mem_we_o are 0; mem_be_o, mem_adr_o, mem_d_o, q_o are 0; all applied at the first rising edge with rst_i=1.
- Reset mid-operation: mem_req_o drops at that edge. Any later mem_ack_i for the aborted beat is ignored. No ack_o or misaligned_o is issued.
- Error latency: request sampled in IDLE at edge k → misaligned_o=1 in cycle k+1, 0 in k+2. A new request can be accepted at edge k+2.
- Access latency: mem_req_o rises the cycle after acceptance. ack_o rises the cycle after the last mem_ack_i. Minimum single-beat latency is 3 cycles, two-beat is 4 cycles.
- Beats: mem_req_o stays high with stable outputs until mem_ack_i. Beat 1 is requested the cycle after beat-0 ack; no idle gap is required on the bus.
- ack_o and misaligned_o are never high together. Both go high only for the request sampled at acceptance; the CPU must drop or change req_i during the pulse cycle.

## Test plan
- XLEN=64, load WORD at 0x1004, mem_q_i=0xDEADBEEF_00000000 → one beat: adr 0x1000, be 0xF0; q_o=0xDEADBEEF, ack 3 cycles after accept.
- XLEN=64, SPLIT_EN=1, store DWORD at 0x2006, d_i=0x1122334455667788 → beat 0: adr 0x2000, be 0xC0, data[63:48]=0x7788; beat 1: adr 0x2008, be 0x3F, data[47:0]=0x112233445566.
- XLEN=32, split load HWORD at 0x0003, beat-0 q 0xAB000000, beat-1 q 0x000000CD → q_o=0x0000CDAB.
- SPLIT_EN=0, load WORD at 0x1002 → misaligned_o=1 exactly one cycle after accept, mem_req_o never rises. Fetch at 0x1002 with HAS_RVC=0 → same; with HAS_RVC=1 → normal single beat.
- XLEN=32, size DWORD, and size code 3'b111 → misaligned_o pulse in both cases.
- Split store at 0xFFFF_FFFE (XLEN=32, WORD): beat 1 adr wraps to 0x0. Separately, assert rst_i during BEAT1 → next cycle mem_req_o=0, state IDLE, no ack_o; a late mem_ack_i produces no ack_o.

Source files
------------

// File: rtl/pu_riscv_memalign.sv
//==============================================================================
//  Module   : pu_riscv_memalign
//  Brief    : Natural-alignment checker and XLEN-aligned access splitter
//             between the CPU load/store/fetch path and the memory bus.
//             Misaligned data accesses become one or two byte-enabled beats
//             (read data merged back) or raise a one-cycle exception.
//  Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module pu_riscv_memalign #(
    parameter int XLEN     = 64,
    parameter int HAS_RVC  = 1,
    parameter int SPLIT_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              instruction_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   adr_i,
    input  logic [2:0]        size_i,
    input  logic [XLEN-1:0]   d_i,
    output logic              ack_o,
    output logic [XLEN-1:0]   q_o,
    output logic              misaligned_o,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_d_o,
    input  logic              mem_ack_i,
    input  logic [XLEN-1:0]   mem_q_i
);

    localparam int c_B  = XLEN / 8;
    localparam int c_LB = $clog2(c_B);

    // Access size codes shared with the bus interface unit
    localparam logic [2:0] c_BYTE  = 3'b000;
    localparam logic [2:0] c_HWORD = 3'b001;
    localparam logic [2:0] c_WORD  = 3'b010;
    localparam logic [2:0] c_DWORD = 3'b011;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_BEAT0 = 3'd1;
    localparam logic [2:0] c_ST_BEAT1 = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    function automatic logic [3:0] f_nbytes(input logic [2:0] sz);
        case (sz)
            c_HWORD: return 4'd2;
            c_WORD:  return 4'd4;
            c_DWORD: return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [XLEN-1:0]   r_adr;
    logic [XLEN-1:0]   r_d;
    logic [XLEN-1:0]   r_q0;
    logic [XLEN-1:0]   r_q1;
    logic [2:0]        r_size;
    logic              r_we;
    logic              r_instr;

    logic [3:0]        w_in_n;
    logic              w_in_illegal;
    logic              w_in_misal;
    logic              w_fetch_err;
    logic              w_in_err;

    logic [3:0]        w_n;
    logic [c_LB-1:0]   w_off;
    logic [c_LB+2:0]   w_shift;
    logic [2*c_B-1:0]  w_mask;
    logic [2*XLEN-1:0] w_sdata;
    logic              w_beat1;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_qmask;
    logic [XLEN-1:0]   w_q;

    // Classify the live request: illegal size, fetch alignment, data alignment
    always_comb begin
        w_in_n       = f_nbytes(size_i);
        w_in_illegal = 1'b0;
        case (size_i)
            c_BYTE, c_HWORD, c_WORD: w_in_illegal = 1'b0;
            c_DWORD:                 w_in_illegal = (XLEN == 32);
            default:                 w_in_illegal = 1'b1;
        endcase
        w_in_misal  = |(adr_i[3:0] & (w_in_n - 4'd1));
        w_fetch_err = (HAS_RVC != 0) ? adr_i[0] : |adr_i[1:0];
        if (instruction_i)
            w_in_err = w_in_illegal | w_fetch_err;
        else
            w_in_err = w_in_illegal | ((SPLIT_EN == 0) & w_in_misal);
    end

    // Beat geometry and load merge derived from the captured request only
    always_comb begin
        w_n     = f_nbytes(r_size);
        w_off   = r_adr[c_LB-1:0];
        w_shift = {w_off, 3'b000};
        w_mask  = ~({(2*c_B){1'b1}} << w_n) << w_off;
        w_sdata = {{XLEN{1'b0}}, r_d} << w_shift;
        // Fetches never get a second beat, even if the mask spills over
        w_beat1 = (|w_mask[2*c_B-1:c_B]) & ~r_instr;
        w_base  = {r_adr[XLEN-1:c_LB], {c_LB{1'b0}}};
        w_qmask = ~({XLEN{1'b1}} << {w_n, 3'b000});
        w_q     = XLEN'({r_q1, r_q0} >> w_shift) & w_qmask;
    end

    // Request capture and beat read-data holding registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_adr   <= '0;
            r_d     <= '0;
            r_q0    <= '0;
            r_q1    <= '0;
            r_size  <= c_BYTE;
            r_we    <= 1'b0;
            r_instr <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE && req_i && !w_in_err) begin
                r_adr   <= adr_i;
                r_d     <= d_i;
                r_size  <= size_i;
                r_we    <= we_i & ~instruction_i;
                r_instr <= instruction_i;
                r_q1    <= '0;
            end
            if (r_state == c_ST_BEAT0 && mem_ack_i) r_q0 <= mem_q_i;
            if (r_state == c_ST_BEAT1 && mem_ack_i) r_q1 <= mem_q_i;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (req_i) w_next = w_in_err ? c_ST_ERR : c_ST_BEAT0;
            c_ST_BEAT0: if (mem_ack_i) w_next = w_beat1 ? c_ST_BEAT1 : c_ST_DONE;
            c_ST_BEAT1: if (mem_ack_i) w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            c_ST_ERR:   w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // Outputs decoded from state; everything is zero outside its active state
    always_comb begin
        ack_o        = 1'b0;
        q_o          = '0;
        misaligned_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_adr_o    = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_d_o      = '0;
        case (r_state)
            c_ST_BEAT0: begin
                mem_req_o = 1'b1;
                mem_adr_o = w_base;
                mem_we_o  = r_we;
                mem_be_o  = w_mask[c_B-1:0];
                mem_d_o   = w_sdata[XLEN-1:0];
            end
            c_ST_BEAT1: begin
                mem_req_o = 1'b1;
                mem_adr_o = w_base + XLEN'(c_B);
                mem_we_o  = r_we;
                mem_be_o  = w_mask[2*c_B-1:c_B];
                mem_d_o   = w_sdata[2*XLEN-1:XLEN];
            end
            c_ST_DONE: begin
                ack_o = 1'b1;
                q_o   = w_q;
            end
            c_ST_ERR:  misaligned_o = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pu_riscv_memalign.sv
//==============================================================================
//  Module   : tb_pu_riscv_memalign
//  Brief    : Scoreboard bench for pu_riscv_memalign. Three instances:
//             A = XLEN64/RVC/split, B = XLEN32/RVC/split,
//             C = XLEN32/no-RVC/no-split. Expected beats and results are
//             queued per request and checked as the selected DUT responds.
//  Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pu_riscv_memalign;

    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;
    localparam logic [2:0] SZ_D = 3'b011;

    typedef struct {
        logic [63:0] adr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] d;
        logic [63:0] rd;
    } beat_t;

    typedef struct {
        logic        err;
        logic        chkq;
        logic [63:0] q;
        int          lat;
    } res_t;

    beat_t exp_beats[$];
    res_t  exp_res[$];
    int    nvec = 0;
    int    nerr = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dsel;
    logic        t_req, t_instr, t_we, t_mack;
    logic [63:0] t_adr, t_d, t_mq;
    logic [2:0]  t_size;

    always #5 clk = ~clk;

    logic reqA, reqB, reqC;
    assign reqA = t_req & (dsel == 2'd0);
    assign reqB = t_req & (dsel == 2'd1);
    assign reqC = t_req & (dsel == 2'd2);

    logic        aAck, aMis, aMreq, aMwe;
    logic [63:0] aQ, aMadr, aMd;
    logic [7:0]  aMbe;
    logic        bAck, bMis, bMreq, bMwe;
    logic [31:0] bQ, bMadr, bMd;
    logic [3:0]  bMbe;
    logic        cAck, cMis, cMreq, cMwe;
    logic [31:0] cQ, cMadr, cMd;
    logic [3:0]  cMbe;

    pu_riscv_memalign #(.XLEN(64), .HAS_RVC(1), .SPLIT_EN(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(reqA), .instruction_i(t_instr),
        .we_i(t_we), .adr_i(t_adr), .size_i(t_size), .d_i(t_d),
        .ack_o(aAck), .q_o(aQ), .misaligned_o(aMis), .mem_req_o(aMreq),
        .mem_adr_o(aMadr), .mem_we_o(aMwe), .mem_be_o(aMbe), .mem_d_o(aMd),
        .mem_ack_i(t_mack), .mem_q_i(t_mq));

    pu_riscv_memalign #(.XLEN(32), .HAS_RVC(1), .SPLIT_EN(1)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(reqB), .instruction_i(t_instr),
        .we_i(t_we), .adr_i(t_adr[31:0]), .size_i(t_size), .d_i(t_d[31:0]),
        .ack_o(bAck), .q_o(bQ), .misaligned_o(bMis), .mem_req_o(bMreq),
        .mem_adr_o(bMadr), .mem_we_o(bMwe), .mem_be_o(bMbe), .mem_d_o(bMd),
        .mem_ack_i(t_mack), .mem_q_i(t_mq[31:0]));

    pu_riscv_memalign #(.XLEN(32), .HAS_RVC(0), .SPLIT_EN(0)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(reqC), .instruction_i(t_instr),
        .we_i(t_we), .adr_i(t_adr[31:0]), .size_i(t_size), .d_i(t_d[31:0]),
        .ack_o(cAck), .q_o(cQ), .misaligned_o(cMis), .mem_req_o(cMreq),
        .mem_adr_o(cMadr), .mem_we_o(cMwe), .mem_be_o(cMbe), .mem_d_o(cMd),
        .mem_ack_i(t_mack), .mem_q_i(t_mq[31:0]));

    // Observed outputs of the selected instance, zero-extended to 64 bits
    logic        o_ack, o_mis, o_mreq, o_mwe;
    logic [63:0] o_q, o_madr, o_md;
    logic [7:0]  o_mbe;
    always_comb begin
        o_ack = aAck; o_mis = aMis; o_mreq = aMreq; o_mwe = aMwe;
        o_q = aQ; o_madr = aMadr; o_md = aMd; o_mbe = aMbe;
        if (dsel == 2'd1) begin
            o_ack = bAck; o_mis = bMis; o_mreq = bMreq; o_mwe = bMwe;
            o_q = {32'd0, bQ}; o_madr = {32'd0, bMadr}; o_md = {32'd0, bMd}; o_mbe = {4'd0, bMbe};
        end else if (dsel == 2'd2) begin
            o_ack = cAck; o_mis = cMis; o_mreq = cMreq; o_mwe = cMwe;
            o_q = {32'd0, cQ}; o_madr = {32'd0, cMadr}; o_md = {32'd0, cMd}; o_mbe = {4'd0, cMbe};
        end
    end

    task automatic push_beat(input logic [63:0] adr, input logic we, input logic [7:0] be,
                             input logic [63:0] d, input logic [63:0] rd);
        beat_t b;
        b.adr = adr; b.we = we; b.be = be; b.d = d; b.rd = rd;
        exp_beats.push_back(b);
    endtask

    task automatic push_res(input logic err, input logic chkq, input logic [63:0] q, input int lat);
        res_t r;
        r.err = err; r.chkq = chkq; r.q = q; r.lat = lat;
        exp_res.push_back(r);
    endtask

    // Drive one request on the selected DUT, act as memory with ws wait states
    task automatic run_op(input logic instr, input logic we, input logic [63:0] adr,
                          input logic [2:0] size, input logic [63:0] d, input int ws);
        beat_t cur;
        res_t  r;
        bit    have = 0;
        bit    done = 0;
        int    wc = 0;
        int    cyc = 0;
        t_instr = instr; t_we = we; t_adr = adr; t_size = size; t_d = d;
        t_req = 1'b1; t_mack = 1'b0;
        @(posedge clk); #1;
        while (!done && cyc < 60) begin
            t_mack = 1'b0;
            if (o_mreq) begin
                if (!have) begin
                    if (exp_beats.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_beat adr=%h be=%h (no beat expected)", o_madr, o_mbe);
                        t_mack = 1'b1; t_mq = '0;
                    end else begin
                        cur = exp_beats.pop_front(); have = 1; wc = 0;
                    end
                end
                if (have) begin
                    nvec++;
                    if (o_madr !== cur.adr || o_mbe !== cur.be || o_mwe !== cur.we ||
                        (cur.we && o_md !== cur.d)) begin
                        nerr++;
                        $display("FAIL beat got adr=%h be=%h we=%b d=%h, expected adr=%h be=%h we=%b d=%h",
                                 o_madr, o_mbe, o_mwe, o_md, cur.adr, cur.be, cur.we, cur.d);
                    end
                    if (wc >= ws) begin
                        t_mack = 1'b1; t_mq = cur.rd; have = 0;
                    end else begin
                        t_mq = 64'hBAD0_BAD0_BAD0_BAD0; wc++;
                    end
                end
            end
            if (o_ack || o_mis) begin
                done = 1; t_req = 1'b0;
                nvec++;
                if (exp_res.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_result ack=%b mis=%b", o_ack, o_mis);
                end else begin
                    r = exp_res.pop_front();
                    if (o_mis !== r.err || o_ack !== !r.err || cyc !== r.lat ||
                        (r.chkq && o_q !== r.q)) begin
                        nerr++;
                        $display("FAIL result got mis=%b ack=%b lat=%0d q=%h, expected mis=%b ack=%b lat=%0d q=%h",
                                 o_mis, o_ack, cyc, o_q, r.err, !r.err, r.lat, r.q);
                    end
                end
            end
            @(posedge clk); #1; cyc++;
        end
        t_mack = 1'b0; t_req = 1'b0;
        nvec++;
        if (!done) begin
            nerr++;
            $display("FAIL timeout got no ack/misaligned within %0d cycles, expected a pulse", cyc);
        end
        nvec++;
        if (o_ack !== 1'b0 || o_mis !== 1'b0 || o_mreq !== 1'b0) begin
            nerr++;
            $display("FAIL pulse_width got ack=%b mis=%b mreq=%b after pulse, expected 000", o_ack, o_mis, o_mreq);
        end
        nvec++;
        if (exp_beats.size() != 0 || exp_res.size() != 0) begin
            nerr++;
            $display("FAIL leftover got %0d beats %0d results unconsumed, expected 0 0",
                     exp_beats.size(), exp_res.size());
            exp_beats.delete(); exp_res.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; t_req = 1'b0; t_mack = 1'b0; t_instr = 1'b0; t_we = 1'b0;
        t_adr = '0; t_d = '0; t_size = SZ_B; t_mq = '0; dsel = 2'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            dsel = 2'(i); #1;
            nvec++;
            if ({o_ack, o_mis, o_mreq, o_mwe} !== 4'b0 || o_q !== '0 || o_madr !== '0 ||
                o_md !== '0 || o_mbe !== '0) begin
                nerr++;
                $display("FAIL reset_dut%0d got ack=%b mis=%b mreq=%b we=%b q=%h adr=%h be=%h d=%h, expected all 0",
                         i, o_ack, o_mis, o_mreq, o_mwe, o_q, o_madr, o_mbe, o_md);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; dsel = 2'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word64();
        dsel = 2'd0;
        push_beat(64'h1000, 1'b0, 8'hF0, 64'h0, 64'hDEADBEEF_00000000);
        push_res(1'b0, 1'b1, 64'hDEADBEEF, 1);
        run_op(1'b0, 1'b0, 64'h1004, SZ_W, 64'h0, 0);
        push_beat(64'h3000, 1'b0, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);
        push_res(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1);
        run_op(1'b0, 1'b0, 64'h3000, SZ_D, 64'h0, 0);
    endtask

    task automatic test_split_store64();
        dsel = 2'd0;
        push_beat(64'h2000, 1'b1, 8'hC0, 64'h7788_0000_0000_0000, 64'h0);
        push_beat(64'h2008, 1'b1, 8'h3F, 64'h0000_1122_3344_5566, 64'h0);
        push_res(1'b0, 1'b0, 64'h0, 2);
        run_op(1'b0, 1'b1, 64'h2006, SZ_D, 64'h1122334455667788, 0);
    endtask

    task automatic test_split_wait64();
        dsel = 2'd0;
        push_beat(64'h1000, 1'b0, 8'h80, 64'h0, 64'hEE00_0000_0000_0000);
        push_beat(64'h1008, 1'b0, 8'h01, 64'h0, 64'h0000_0000_0000_00FF);
        push_res(1'b0, 1'b1, 64'hFFEE, 6);
        run_op(1'b0, 1'b0, 64'h1007, SZ_H, 64'h0, 2);
    endtask

    task automatic test_fetch();
        dsel = 2'd0;
        push_beat(64'h1000, 1'b0, 8'h3C, 64'h0, 64'h0000_1234_5678_0000);
        push_res(1'b0, 1'b1, 64'h12345678, 1);
        run_op(1'b1, 1'b1, 64'h1002, SZ_W, 64'hFFFF, 0);
        push_res(1'b1, 1'b0, 64'h0, 0);
        run_op(1'b1, 1'b0, 64'h1001, SZ_W, 64'h0, 0);
        dsel = 2'd2;
        push_res(1'b1, 1'b0, 64'h0, 0);
        run_op(1'b1, 1'b0, 64'h1002, SZ_W, 64'h0, 0);
    endtask

    task automatic test_split32();
        dsel = 2'd1;
        push_beat(64'h0, 1'b0, 8'h08, 64'h0, 64'hAB000000);
        push_beat(64'h4, 1'b0, 8'h01, 64'h0, 64'h000000CD);
        push_res(1'b0, 1'b1, 64'hCDAB, 2);
        run_op(1'b0, 1'b0, 64'h3, SZ_H, 64'h0, 0);
        push_beat(64'hFFFF_FFFC, 1'b1, 8'h0C, 64'hC3D4_0000, 64'h0);
        push_beat(64'h0, 1'b1, 8'h03, 64'h0000_A1B2, 64'h0);
        push_res(1'b0, 1'b0, 64'h0, 2);
        run_op(1'b0, 1'b1, 64'hFFFF_FFFE, SZ_W, 64'hA1B2C3D4, 0);
    endtask

    task automatic test_nosplit();
        dsel = 2'd2;
        push_res(1'b1, 1'b0, 64'h0, 0);
        run_op(1'b0, 1'b0, 64'h1002, SZ_W, 64'h0, 0);
        push_beat(64'h1000, 1'b0, 8'h08, 64'h0, 64'h5A123456);
        push_res(1'b0, 1'b1, 64'h5A, 1);
        run_op(1'b0, 1'b0, 64'h1003, SZ_B, 64'h0, 0);
    endtask

    task automatic test_illegal();
        dsel = 2'd2;
        push_res(1'b1, 1'b0, 64'h0, 0);
        run_op(1'b0, 1'b0, 64'h1000, SZ_D, 64'h0, 0);
        push_res(1'b1, 1'b0, 64'h0, 0);
        run_op(1'b0, 1'b0, 64'h1000, 3'b111, 64'h0, 0);
        dsel = 2'd0;
        push_res(1'b1, 1'b0, 64'h0, 0);
        run_op(1'b0, 1'b1, 64'h1000, 3'b111, 64'h0, 0);
    endtask

    task automatic test_back_to_back();
        dsel = 2'd1;
        push_beat(64'h4, 1'b1, 8'h02, 64'h0000_1100, 64'h0);
        push_res(1'b0, 1'b0, 64'h0, 1);
        run_op(1'b0, 1'b1, 64'h5, SZ_B, 64'h11, 0);
        push_beat(64'h8, 1'b0, 8'h0F, 64'h0, 64'h89AB_CDEF);
        push_res(1'b0, 1'b1, 64'h89AB_CDEF, 1);
        run_op(1'b0, 1'b0, 64'h8, SZ_W, 64'h0, 0);
        push_beat(64'hC, 1'b0, 8'h0C, 64'h0, 64'h7766_0000);
        push_res(1'b0, 1'b1, 64'h7766, 2);
        run_op(1'b0, 1'b0, 64'hE, SZ_H, 64'h0, 1);
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        dsel = 2'd1;
        t_instr = 1'b0; t_we = 1'b1; t_adr = 64'hFFFF_FFFE; t_size = SZ_W; t_d = 64'hA1B2C3D4;
        t_req = 1'b1;
        @(posedge clk); #1;
        t_mack = 1'b1;
        @(posedge clk); #1;
        t_mack = 1'b0;
        nvec++;
        if (o_mreq !== 1'b1 || o_madr !== 64'h0 || o_mbe !== 8'h03) begin
            nerr++;
            $display("FAIL rstmid_beat1 got mreq=%b adr=%h be=%h, expected 1 0 03", o_mreq, o_madr, o_mbe);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; t_req = 1'b0;
        nvec++;
        if (o_mreq !== 1'b0 || o_ack !== 1'b0 || o_mis !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_drop got mreq=%b ack=%b mis=%b, expected 000", o_mreq, o_ack, o_mis);
        end
        t_mack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            t_mack = 1'b0;
            if (o_mreq || o_ack || o_mis) bad = 1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL rstmid_late_ack got activity after late mem_ack, expected none");
        end
    endtask

    initial begin
        test_reset();
        test_load_word64();
        test_split_store64();
        test_split_wait64();
        test_fetch();
        test_split32();
        test_nosplit();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
